// File: rtl/fbuff_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : fbuff_writer_if
// Description : Bundle of the tile-pixel stream, frame-buffer write port and
//               status signals used by fbuff_writer.
//               master : pixel/strobe/grant source (drives *_i signals)
//               slave  : fbuff_writer (drives *_o signals)
//               Signals:
//                 sof_i         start-of-frame strobe
//                 pxl_valid_i   tile pixel valid
//                 pxl_data_i    tile pixel value   [PXL_WIDTH]
//                 pxl_ready_o   pixel accepted when high with pxl_valid_i
//                 wr_gnt_i      shared frame-buffer port granted this cycle
//                 fbuff_addr_o  write row address  [FBUFF_ADDR_WIDTH]
//                 fbuff_data_o  packed row data    [FBUFF_DATA_WIDTH]
//                 fbuff_en_o    frame-buffer enable
//                 fbuff_wen_o   frame-buffer write enable
//                 frame_done_o  one-cycle pulse after the last row is written
//                 err_o         sticky frame-restart error
// Revision    : 1.0 - initial release
// ============================================================================
interface fbuff_writer_if #(
    parameter int PXL_WIDTH        = 12,
    parameter int TILE_PER_ROW     = 5,
    parameter int FBUFF_DEPTH      = 19200,
    parameter int FBUFF_ADDR_WIDTH = $clog2(FBUFF_DEPTH),
    parameter int FBUFF_DATA_WIDTH = TILE_PER_ROW * PXL_WIDTH
);
    logic                        sof_i;
    logic                        pxl_valid_i;
    logic [PXL_WIDTH-1:0]        pxl_data_i;
    logic                        pxl_ready_o;
    logic                        wr_gnt_i;
    logic [FBUFF_ADDR_WIDTH-1:0] fbuff_addr_o;
    logic [FBUFF_DATA_WIDTH-1:0] fbuff_data_o;
    logic                        fbuff_en_o;
    logic                        fbuff_wen_o;
    logic                        frame_done_o;
    logic                        err_o;

    modport master (
        output sof_i, pxl_valid_i, pxl_data_i, wr_gnt_i,
        input  pxl_ready_o, fbuff_addr_o, fbuff_data_o, fbuff_en_o,
               fbuff_wen_o, frame_done_o, err_o
    );

    modport slave (
        input  sof_i, pxl_valid_i, pxl_data_i, wr_gnt_i,
        output pxl_ready_o, fbuff_addr_o, fbuff_data_o, fbuff_en_o,
               fbuff_wen_o, frame_done_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/fbuff_writer.sv
`default_nettype none
// ============================================================================
// Module      : fbuff_writer
// Description : Packs TILE_PER_ROW tile pixels into one frame-buffer row and
//               writes the row through a shared, arbitrated frame-buffer
//               port. Rows are written at consecutive addresses from 0 to
//               FBUFF_DEPTH-1; sof_i restarts the frame at row 0.
//               Ports:
//                 clk   clock
//                 rstn  asynchronous active-low reset
//                 bus   fbuff_writer_if.slave (pixel stream, write port,
//                       frame_done_o, err_o)
//               Optional feature macro: FBUFF_WRITER_ERR_EN
//                 defined   : err_o latches on a frame restart that arrives
//                             mid-frame (sticky until rstn)
//                 undefined : err_o tied low, no error logic
// Revision    : 1.0 - initial release
// ============================================================================
module fbuff_writer #(
    parameter int PXL_WIDTH        = 12,
    parameter int TILE_PER_ROW     = 5,
    parameter int FBUFF_DEPTH      = 19200,
    parameter int FBUFF_ADDR_WIDTH = $clog2(FBUFF_DEPTH),
    parameter int FBUFF_DATA_WIDTH = TILE_PER_ROW * PXL_WIDTH
) (
    input  logic          clk,
    input  logic          rstn,
    fbuff_writer_if.slave bus
);

    localparam int c_SLOT_WIDTH = (TILE_PER_ROW > 1) ? $clog2(TILE_PER_ROW) : 1;
    localparam logic [c_SLOT_WIDTH-1:0]     c_LAST_SLOT = c_SLOT_WIDTH'(TILE_PER_ROW - 1);
    localparam logic [FBUFF_ADDR_WIDTH-1:0] c_LAST_ADDR = FBUFF_ADDR_WIDTH'(FBUFF_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t                      r_state;
    logic [FBUFF_ADDR_WIDTH-1:0] r_addr;
    logic [c_SLOT_WIDTH-1:0]     r_slot;
    logic [FBUFF_DATA_WIDTH-1:0] r_row;
    logic                        r_pxl_ready;
    logic                        r_wr_en;
    logic [FBUFF_ADDR_WIDTH-1:0] r_wr_addr;
    logic [FBUFF_DATA_WIDTH-1:0] r_wr_data;
    logic                        r_frame_done;

    logic                        w_accept;
    logic [FBUFF_DATA_WIDTH-1:0] w_row_next;

    // r_pxl_ready is high exactly while in FILL, so it doubles as the
    // "accepting" qualifier.
    assign w_accept = bus.pxl_valid_i & r_pxl_ready;

    // Row contents including the pixel offered this cycle; used both to
    // accumulate and to launch the write without an extra cycle.
    always_comb begin
        w_row_next = r_row;
        w_row_next[r_slot*PXL_WIDTH +: PXL_WIDTH] = bus.pxl_data_i;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_slot       <= '0;
            r_row        <= '0;
            r_pxl_ready  <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.sof_i) begin
                        r_state     <= ST_FILL;
                        r_addr      <= '0;
                        r_slot      <= '0;
                        r_row       <= '0;
                        r_pxl_ready <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (bus.sof_i) begin
                        // Restart wins over a pixel offered in the same cycle.
                        r_addr <= '0;
                        r_slot <= '0;
                        r_row  <= '0;
                    end else if (w_accept) begin
                        r_row <= w_row_next;
                        if (r_slot == c_LAST_SLOT) begin
                            r_state     <= ST_WRITE;
                            r_pxl_ready <= 1'b0;
                            r_wr_en     <= 1'b1;
                            r_wr_addr   <= r_addr;
                            r_wr_data   <= w_row_next;
                        end else begin
                            r_slot <= r_slot + 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (bus.sof_i) begin
                        // A coincident grant still commits the current row,
                        // but the restart decides where we go next.
                        r_state     <= ST_FILL;
                        r_addr      <= '0;
                        r_slot      <= '0;
                        r_row       <= '0;
                        r_pxl_ready <= 1'b1;
                        r_wr_en     <= 1'b0;
                    end else if (bus.wr_gnt_i) begin
                        r_wr_en <= 1'b0;
                        r_slot  <= '0;
                        r_row   <= '0;
                        if (r_addr == c_LAST_ADDR) begin
                            r_state      <= ST_IDLE;
                            r_addr       <= '0;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_state     <= ST_FILL;
                            r_addr      <= r_addr + 1'b1;
                            r_pxl_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_pxl_ready <= 1'b0;
                    r_wr_en     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pxl_ready_o  = r_pxl_ready;
    assign bus.fbuff_en_o   = r_wr_en;
    assign bus.fbuff_wen_o  = r_wr_en;
    assign bus.fbuff_addr_o = r_wr_addr;
    assign bus.fbuff_data_o = r_wr_data;
    assign bus.frame_done_o = r_frame_done;

`ifdef FBUFF_WRITER_ERR_EN
    logic r_err;

    // A restart is an error whenever it cuts a frame short: any progress in
    // FILL, or a row waiting in WRITE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err <= 1'b0;
        end else if (bus.sof_i &&
                     ((r_state == ST_FILL && (r_slot != '0 || r_addr != '0)) ||
                      r_state == ST_WRITE)) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err_o = r_err;
`else
    assign bus.err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fbuff_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fbuff_writer
// Description : Self-checking bench for fbuff_writer. A queue-based row
//               model predicts ready/enable/address/data/done/error every
//               cycle; directed scenarios add literal expectations.
//               Honours FBUFF_WRITER_ERR_EN for the err_o expectation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fbuff_writer;

    localparam int c_P  = 12;
    localparam int c_T  = 5;
    localparam int c_D  = 24;
    localparam int c_AW = $clog2(c_D);
    localparam int c_DW = c_T * c_P;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fbuff_writer_if #(.PXL_WIDTH(c_P), .TILE_PER_ROW(c_T), .FBUFF_DEPTH(c_D)) bus ();

    fbuff_writer #(
        .PXL_WIDTH        (c_P),
        .TILE_PER_ROW     (c_T),
        .FBUFF_DEPTH      (c_D),
        .FBUFF_ADDR_WIDTH (c_AW),
        .FBUFF_DATA_WIDTH (c_DW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        int              addr;
        logic [c_DW-1:0] data;
    } wr_t;

    int tests = 0;
    int fails = 0;
    int en_cnt = 0;
    int done_cnt = 0;

    // model state
    bit             m_accepting;
    bit             m_pend;
    bit             m_err;
    bit             e_done;
    int             m_row;
    int             e_addr;
    logic [c_DW-1:0] e_data;
    logic [c_P-1:0] m_pix[$];

    logic [c_P-1:0] src[$];
    logic [c_P-1:0] pix_save[$];
    wr_t            dut_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [c_DW-1:0] pack_row();
        logic [c_DW-1:0] v;
        v = '0;
        for (int i = 0; i < m_pix.size(); i++) v[i*c_P +: c_P] = m_pix[i];
        return v;
    endfunction

    task automatic model_reset();
        m_accepting = 0;
        m_pend      = 0;
        m_err       = 0;
        e_done      = 0;
        m_row       = 0;
        e_addr      = 0;
        e_data      = '0;
        m_pix.delete();
    endtask

    // Row-level model: a row is a queue of pixels; a full queue becomes a
    // pending write that leaves on grant (or is dropped on restart).
    task automatic model_step();
        if (!rstn) begin
            model_reset();
            return;
        end
        e_done = 0;
        if (m_pend) begin
            if (bus.sof_i) begin
                m_err       = 1;
                m_pend      = 0;
                m_accepting = 1;
                m_row       = 0;
                m_pix.delete();
            end else if (bus.wr_gnt_i) begin
                m_pend = 0;
                m_pix.delete();
                if (m_row == c_D - 1) begin
                    m_row  = 0;
                    e_done = 1;
                end else begin
                    m_row++;
                    m_accepting = 1;
                end
            end
        end else if (m_accepting) begin
            if (bus.sof_i) begin
                if (m_pix.size() > 0 || m_row > 0) m_err = 1;
                m_row = 0;
                m_pix.delete();
            end else if (bus.pxl_valid_i) begin
                m_pix.push_back(bus.pxl_data_i);
                if (m_pix.size() == c_T) begin
                    m_pend      = 1;
                    m_accepting = 0;
                    e_addr      = m_row;
                    e_data      = pack_row();
                end
            end
        end else if (bus.sof_i) begin
            m_accepting = 1;
            m_row       = 0;
            m_pix.delete();
        end
    endtask

    task automatic compare();
        chk("ready", bus.pxl_ready_o, m_accepting);
        chk("en",    bus.fbuff_en_o,  m_pend);
        chk("wen",   bus.fbuff_wen_o, m_pend);
        chk("done",  bus.frame_done_o, e_done);
`ifdef FBUFF_WRITER_ERR_EN
        chk("err",   bus.err_o, m_err);
`else
        chk("err",   bus.err_o, 1'b0);
`endif
        if (m_pend) begin
            chk("addr", bus.fbuff_addr_o, e_addr);
            chk("data", bus.fbuff_data_o, e_data);
        end
    endtask

    task automatic step();
        if (rstn && bus.fbuff_en_o && bus.fbuff_wen_o && bus.wr_gnt_i)
            dut_log.push_back('{int'(bus.fbuff_addr_o), bus.fbuff_data_o});
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        if (bus.fbuff_en_o)   en_cnt++;
        if (bus.frame_done_o) done_cnt++;
    endtask

    task automatic drive_idle();
        bus.sof_i       = 0;
        bus.pxl_valid_i = 0;
        bus.pxl_data_i  = '0;
        bus.wr_gnt_i    = 0;
    endtask

    task automatic do_reset();
        rstn = 0;
        #1;
        model_reset();
        compare();
        chk("rst_addr", bus.fbuff_addr_o, 0);
        chk("rst_data", bus.fbuff_data_o, 0);
        step();
        step();
        rstn = 1;
    endtask

    task automatic pulse_sof(input bit with_pix);
        bus.sof_i       = 1;
        bus.pxl_valid_i = with_pix;
        bus.pxl_data_i  = c_P'($urandom);
        step();
        bus.sof_i       = 0;
        bus.pxl_valid_i = 0;
    endtask

    task automatic feed(input int gap_pct, input int gnt_pct);
        int guard;
        bit acc;
        guard = 0;
        while ((src.size() > 0 || (m_pend && gnt_pct > 0)) && guard < 5000) begin
            bus.pxl_valid_i = (src.size() > 0) && ($urandom_range(99) >= gap_pct);
            bus.pxl_data_i  = bus.pxl_valid_i ? src[0] : c_P'($urandom);
            bus.wr_gnt_i    = ($urandom_range(99) < gnt_pct);
            acc = bus.pxl_valid_i && m_accepting;
            step();
            if (acc) void'(src.pop_front());
            guard++;
        end
        if (guard >= 5000) begin
            tests++;
            fails++;
            $display("FAIL feed_timeout: got %0d pixels left expected 0", src.size());
            src.delete();
        end
        bus.pxl_valid_i = 0;
        bus.wr_gnt_i    = 0;
    endtask

    function automatic logic [c_DW-1:0] saved_row(input int r);
        logic [c_DW-1:0] v;
        v = '0;
        for (int j = 0; j < c_T; j++) v[j*c_P +: c_P] = pix_save[r*c_T + j];
        return v;
    endfunction

    initial begin
        int base;
        int en0;
        int d0;
        drive_idle();
        @(negedge clk);
        do_reset();

        // Row of pixels 0..4 with grant always.
        base = dut_log.size();
        en0  = en_cnt;
        pulse_sof(0);
        for (int i = 0; i < c_T; i++) src.push_back(c_P'(i));
        feed(0, 100);
        repeat (3) step();
        chk("t1_nwr", dut_log.size() - base, 1);
        if (dut_log.size() > base) begin
            chk("t1_addr", dut_log[base].addr, 0);
            chk("t1_data", dut_log[base].data, 60'h004003002001000);
        end
        chk("t1_en_cycles", en_cnt - en0, 1);

        // Full frame, valid and grant always; then sof coincident with done.
        do_reset();
        pulse_sof(0);
        base = dut_log.size();
        d0   = done_cnt;
        for (int i = 0; i < c_D * c_T; i++) src.push_back(c_P'($urandom));
        feed(0, 100);
        chk("t2_nwr", dut_log.size() - base, c_D);
        for (int i = 0; i < c_D && base + i < dut_log.size(); i++)
            chk("t2_addr", dut_log[base+i].addr, i);
        chk("t2_done_now", bus.frame_done_o, 1);
        chk("t2_idle_ready", bus.pxl_ready_o, 0);
        pulse_sof(0);
        chk("t2_done_once", done_cnt - d0, 1);
        chk("t2_no_err", bus.err_o, 0);
        chk("t2_restart_ready", bus.pxl_ready_o, 1);

        // Grant withheld for 7 cycles of WRITE.
        base = dut_log.size();
        en0  = en_cnt;
        for (int i = 0; i < c_T; i++) src.push_back(c_P'($urandom));
        feed(0, 0);
        bus.wr_gnt_i = 0;
        repeat (7) step();
        bus.wr_gnt_i = 1;
        step();
        bus.wr_gnt_i = 0;
        chk("t3_en_cycles", en_cnt - en0, 8);
        chk("t3_nwr", dut_log.size() - base, 1);
        if (dut_log.size() > base) chk("t3_addr", dut_log[base].addr, 0);

        // Restart after 3 pixels of row 10.
        do_reset();
        pulse_sof(0);
        for (int i = 0; i < 10 * c_T + 3; i++) src.push_back(c_P'($urandom));
        feed(0, 100);
        base = dut_log.size();
        pulse_sof(1);
        for (int i = 0; i < c_T; i++) src.push_back(c_P'($urandom));
        feed(0, 100);
        repeat (2) step();
        chk("t4_nwr", dut_log.size() - base, 1);
        if (dut_log.size() > base) chk("t4_addr", dut_log[base].addr, 0);
`ifdef FBUFF_WRITER_ERR_EN
        chk("t4_err", bus.err_o, 1);
`else
        chk("t4_err", bus.err_o, 0);
`endif

        // Reset while a write to row 5 is pending.
        do_reset();
        pulse_sof(0);
        for (int i = 0; i < 5 * c_T; i++) src.push_back(c_P'($urandom));
        feed(0, 100);
        for (int i = 0; i < c_T; i++) src.push_back(c_P'($urandom));
        feed(0, 0);
        chk("t5_pend_en", bus.fbuff_en_o, 1);
        chk("t5_pend_addr", bus.fbuff_addr_o, 5);
        do_reset();
        chk("t5_rst_err", bus.err_o, 0);
        en0 = en_cnt;
        for (int i = 0; i < 10; i++) begin
            bus.pxl_valid_i = 1;
            bus.pxl_data_i  = c_P'($urandom);
            bus.wr_gnt_i    = 1;
            step();
        end
        drive_idle();
        chk("t5_no_wr", en_cnt - en0, 0);
        base = dut_log.size();
        pulse_sof(0);
        for (int i = 0; i < c_T; i++) src.push_back(c_P'($urandom));
        feed(0, 100);
        chk("t5_nwr", dut_log.size() - base, 1);
        if (dut_log.size() > base) chk("t5_addr", dut_log[base].addr, 0);

        // Gapped vs gap-free packing of the same pixels.
        pix_save.delete();
        for (int i = 0; i < 4 * c_T; i++) pix_save.push_back(c_P'($urandom));
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            pulse_sof(0);
            base = dut_log.size();
            src  = pix_save;
            if (pass == 0) feed(40, 60);
            else           feed(0, 100);
            chk("t6_nwr", dut_log.size() - base, 4);
            for (int r = 0; r < 4 && base + r < dut_log.size(); r++) begin
                chk("t6_addr", dut_log[base+r].addr, r);
                chk("t6_data", dut_log[base+r].data, saved_row(r));
            end
        end

        // Random mix of restarts, gaps and grants against the model.
        do_reset();
        pulse_sof(0);
        for (int i = 0; i < 600; i++) begin
            bus.sof_i       = ($urandom_range(99) < 2);
            bus.pxl_valid_i = ($urandom_range(99) < 70);
            bus.pxl_data_i  = c_P'($urandom);
            bus.wr_gnt_i    = ($urandom_range(99) < 50);
            step();
        end
        drive_idle();
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fbuff_writer.md
FBUFF_WRITER -- requirements
Module: fbuff_writer

Interface
REQ-001 SHALL have parameter PXL_WIDTH, default 12, bits per tile pixel (3 x 4-bit colour).
REQ-002 SHALL have parameter TILE_PER_ROW, default 5, tiles packed per frame-buffer row.
REQ-003 SHALL have parameter FBUFF_DEPTH, default 19200, rows per frame.
REQ-004 SHALL have parameter FBUFF_ADDR_WIDTH, default $clog2(FBUFF_DEPTH), row address width.
REQ-005 SHALL have parameter FBUFF_DATA_WIDTH, default TILE_PER_ROW*PXL_WIDTH, row data width.
REQ-006 SHALL have port clk  input  1  clock.
REQ-007 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port sof_i  input  1  start-of-frame strobe.
REQ-009 SHALL have port pxl_valid_i  input  1  tile pixel valid.
REQ-010 SHALL have port pxl_data_i  input  PXL_WIDTH  tile pixel value.
REQ-011 SHALL have port pxl_ready_o  output  1  tile pixel accepted when high with pxl_valid_i.
REQ-012 SHALL have port wr_gnt_i  input  1  shared frame-buffer port granted this cycle.
REQ-013 SHALL have port fbuff_addr_o  output  FBUFF_ADDR_WIDTH  write row address.
REQ-014 SHALL have port fbuff_data_o  output  FBUFF_DATA_WIDTH  packed row data.
REQ-015 SHALL have port fbuff_en_o  output  1  frame-buffer enable.
REQ-016 SHALL have port fbuff_wen_o  output  1  frame-buffer write enable.
REQ-017 SHALL have port frame_done_o  output  1  one-cycle pulse after final row of frame written.
REQ-018 SHALL have port err_o  output  1  sticky frame-restart error.

Function
REQ-019 SHALL implement FSM states IDLE, FILL, WRITE; all outputs registered.
REQ-020 IDLE: pxl_ready_o=0; sof_i -> FILL next cycle with row address 0, slot 0.
REQ-021 FILL: pxl_ready_o=1; each valid&ready cycle stores pxl_data_i at bits [slot*PXL_WIDTH +: PXL_WIDTH], slot+1; first accepted tile occupies slot 0 (LSBs).
REQ-022 FILL: accept of slot TILE_PER_ROW-1 -> WRITE next cycle; fbuff_en_o=fbuff_wen_o=1 in the cycle immediately after the final accept (latency 1).
REQ-023 WRITE: pxl_ready_o=0; fbuff_en_o, fbuff_wen_o, fbuff_addr_o, fbuff_data_o held stable until a cycle with wr_gnt_i=1 (write commits in that cycle).
REQ-024 On commit with address < FBUFF_DEPTH-1: address+1, slot 0, -> FILL; en/wen low next cycle.
REQ-025 On commit with address = FBUFF_DEPTH-1: address wraps to 0, -> IDLE, frame_done_o=1 for exactly the next cycle.
REQ-026 sof_i in FILL: partial row discarded, address 0, slot 0, remain FILL; no write issued; pixel accepted same cycle is dropped.
REQ-027 sof_i in WRITE without grant: pending write abandoned, en/wen low next cycle, address 0, -> FILL.
REQ-028 sof_i in WRITE with wr_gnt_i=1: write commits at current address; sof_i takes precedence, address 0, -> FILL, no frame_done_o.
REQ-029 sof_i in IDLE coincident with frame_done_o: normal start, no error.
REQ-030 fbuff_en_o and fbuff_wen_o SHALL never be high outside WRITE.

Reset
REQ-031 rstn low SHALL asynchronously force IDLE, address 0, slot 0, packed data 0, and all outputs 0.
REQ-032 Reset mid-frame SHALL abandon any pending write without further en/wen assertion; operation resumes only on next sof_i.

Configuration
REQ-033 Macro FBUFF_WRITER_ERR_EN defined: err_o SHALL set on sof_i received in FILL (slot>0 or address>0) or WRITE, and remain set until rstn.
REQ-034 Macro FBUFF_WRITER_ERR_EN undefined: err_o SHALL be tied 0 and no error logic synthesised; all other behaviour unchanged.

Verification
REQ-035 Reset, sof_i, pixels 0x000..0x004 with wr_gnt_i=1 -> one write, addr 0, data 0x004_003_002_001_000, en/wen high 1 cycle.
REQ-036 Full frame of 96000 pixels, valid always, grant always -> 19200 writes addr 0..19199, frame_done_o single pulse after addr 19199, FSM IDLE.
REQ-037 wr_gnt_i low 7 cycles in WRITE -> addr/data/en/wen stable 8 cycles, pxl_ready_o=0, commit on grant cycle.
REQ-038 sof_i after 3 pixels of row 10 (ERR_EN defined) -> no write for row 10, next write addr 0, err_o=1 sticky; ERR_EN undefined -> err_o=0.
REQ-039 rstn low while in WRITE at addr 5 -> en/wen 0 immediately, addr 0; no write until sof_i.
REQ-040 Random pxl_valid_i gaps -> packed rows identical to gap-free run.
